// File: rtl/pool_pkg.sv
// Shared types and constants for the pooling window generator.
package pool_pkg;

    localparam int unsigned DATA_W = 16;

    typedef logic signed [DATA_W-1:0] pix_t;

    localparam int unsigned WIN_TL = 0;
    localparam int unsigned WIN_TR = 1;
    localparam int unsigned WIN_BL = 2;
    localparam int unsigned WIN_BR = 3;

    // Counter width for a 0..n-1 range, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One-row pixel store: a single synchronous write port and two combinational read ports.
module pool_line_buf
    import pool_pkg::*;
#(
    parameter int unsigned FM_DEPTH = 64,
    parameter int unsigned FM_WIDTH = 28,
    parameter int unsigned AW       = cnt_w(FM_WIDTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         wr_addr,
    input  pix_t [FM_DEPTH-1:0]   wr_data,
    input  logic [AW-1:0]         rd_addr_a,
    input  logic [AW-1:0]         rd_addr_b,
    output pix_t [FM_DEPTH-1:0]   rd_data_a,
    output pix_t [FM_DEPTH-1:0]   rd_data_b
);

    // Deliberately unreset: every entry is rewritten by an even row before it is read.
    pix_t [FM_DEPTH-1:0] mem_q [FM_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = mem_q[rd_addr_a];
    assign rd_data_b = mem_q[rd_addr_b];

endmodule

// File: rtl/pool_window_gen.sv
// Raster-stream to non-overlapping 2x2 window generator for the average-pooling core.
// Optional frame_done output enabled by defining POOL_WIN_FRAME_DONE_EN.
module pool_window_gen
    import pool_pkg::*;
#(
    parameter int unsigned FM_DEPTH  = 64,
    parameter int unsigned FM_WIDTH  = 28,
    parameter int unsigned FM_HEIGHT = 28
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        frame_start,
    input  logic                        pixel_in_valid,
    input  pix_t [FM_DEPTH-1:0]         pixel_in,
    output logic                        window_valid,
    output pix_t [FM_DEPTH-1:0][3:0]    window_out
`ifdef POOL_WIN_FRAME_DONE_EN
    ,
    output logic                        frame_done
`endif
);

    localparam int unsigned CW = cnt_w(FM_WIDTH);
    localparam int unsigned RW = cnt_w(FM_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(FM_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FM_HEIGHT - 1);

    logic [CW-1:0] col_q, col_d, cur_col, rd_col_left;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic          last_col, last_row;
    logic          lb_we, left_we, win_d;

    pix_t [FM_DEPTH-1:0]      left_q;
    pix_t [FM_DEPTH-1:0]      lb_left, lb_right;
    pix_t [FM_DEPTH-1:0][3:0] win_next;

    // frame_start takes effect in the same cycle, so a coincident pixel lands at (0,0).
    always_comb begin
        cur_col  = frame_start ? '0 : col_q;
        cur_row  = frame_start ? '0 : row_q;
        last_col = (cur_col == COL_LAST);
        last_row = (cur_row == ROW_LAST);

        col_d = cur_col;
        row_d = cur_row;
        if (pixel_in_valid) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
            end
        end

        lb_we   = pixel_in_valid & ~cur_row[0];
        left_we = pixel_in_valid &  cur_row[0] & ~cur_col[0];
        win_d   = pixel_in_valid &  cur_row[0] &  cur_col[0];
    end

    // Windows only form on odd columns, so clearing bit 0 yields col-1 without underflow.
    assign rd_col_left = cur_col & ~CW'(1);

    pool_line_buf #(
        .FM_DEPTH (FM_DEPTH),
        .FM_WIDTH (FM_WIDTH),
        .AW       (CW)
    ) u_line_buf (
        .clk       (clk),
        .we        (lb_we),
        .wr_addr   (cur_col),
        .wr_data   (pixel_in),
        .rd_addr_a (rd_col_left),
        .rd_addr_b (cur_col),
        .rd_data_a (lb_left),
        .rd_data_b (lb_right)
    );

    always_comb begin
        win_next = window_out;
        if (win_d) begin
            for (int ch = 0; ch < int'(FM_DEPTH); ch++) begin
                win_next[ch][WIN_TL] = lb_left[ch];
                win_next[ch][WIN_TR] = lb_right[ch];
                win_next[ch][WIN_BL] = left_q[ch];
                win_next[ch][WIN_BR] = pixel_in[ch];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_q        <= '0;
            row_q        <= '0;
            left_q       <= '0;
            window_valid <= 1'b0;
            window_out   <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            window_valid <= win_d;
            window_out   <= win_next;
            if (left_we) begin
                left_q <= pixel_in;
            end
        end
    end

`ifdef POOL_WIN_FRAME_DONE_EN
    // An aborted frame never reaches the last position, so no explicit suppression is needed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= win_d & last_col & last_row;
        end
    end
`endif

endmodule

// File: tb/tb_pool_window_gen.sv
// Self-checking bench for pool_window_gen against a frame-image reference model.
module tb_pool_window_gen;
    import pool_pkg::*;

    localparam int D = 2;
    localparam int W = 4;
    localparam int H = 4;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 frame_start;
    logic                 pixel_in_valid;
    pix_t [D-1:0]         pixel_in;
    logic                 window_valid;
    pix_t [D-1:0][3:0]    window_out;
`ifdef POOL_WIN_FRAME_DONE_EN
    logic                 frame_done;
`endif

    pool_window_gen #(
        .FM_DEPTH  (D),
        .FM_WIDTH  (W),
        .FM_HEIGHT (H)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .frame_start    (frame_start),
        .pixel_in_valid (pixel_in_valid),
        .pixel_in       (pixel_in),
        .window_valid   (window_valid),
        .window_out     (window_out)
`ifdef POOL_WIN_FRAME_DONE_EN
        ,
        .frame_done     (frame_done)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: position in frame, image of received pixels, last expected window.
    int                mr, mc;
    pix_t [D-1:0]      img [H][W];
    pix_t [D-1:0][3:0] held;
    logic              prev_v;
    int                pulses, dones;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic pix_t [D-1:0] pat(input int r, input int c);
        pix_t [D-1:0] p;
        p[0] = pix_t'(r * 16 + c);
        p[1] = pix_t'(-(r * 16 + c));
        return p;
    endfunction

    function automatic pix_t [D-1:0] rnd_pix();
        pix_t [D-1:0] p;
        p = $urandom;
        return p;
    endfunction

    task automatic model_reset();
        mr     = 0;
        mc     = 0;
        held   = '0;
        prev_v = 1'b0;
    endtask

    // Apply one cycle of input, predict from the model, then check after the edge.
    task automatic step(input bit v, input bit fs, input pix_t [D-1:0] d);
        bit                ew_v;
        bit                ed;
        pix_t [D-1:0][3:0] ew;
        pixel_in_valid = v;
        frame_start    = fs;
        pixel_in       = d;
        ew_v = 1'b0;
        ed   = 1'b0;
        ew   = held;
        if (fs) begin
            mr = 0;
            mc = 0;
        end
        if (v) begin
            img[mr][mc] = d;
            if ((mr % 2 == 1) && (mc % 2 == 1)) begin
                ew_v = 1'b1;
                ed   = (mr == H - 1) && (mc == W - 1);
                for (int ch = 0; ch < D; ch++) begin
                    ew[ch][0] = img[mr-1][mc-1][ch];
                    ew[ch][1] = img[mr-1][mc][ch];
                    ew[ch][2] = img[mr][mc-1][ch];
                    ew[ch][3] = d[ch];
                end
            end
            mc++;
            if (mc == W) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end
        end
        @(posedge clk);
        #1;
        check_eq("window_valid", 128'(window_valid), 128'(ew_v));
        check_eq("window_out", 128'(window_out), 128'(ew));
        check_eq("back_to_back", 128'(prev_v & window_valid), 128'(0));
`ifdef POOL_WIN_FRAME_DONE_EN
        check_eq("frame_done", 128'(frame_done), 128'(ed));
        if (frame_done) dones++;
`endif
        if (window_valid) pulses++;
        held   = ew;
        prev_v = window_valid;
    endtask

    task automatic send_rows(input int r0, input int c0, input int r1, input int c1,
                             input int gap, input bit fs_first);
        for (int r = r0; r <= r1; r++) begin
            for (int c = 0; c < W; c++) begin
                if ((r == r0 && c < c0) || (r == r1 && c > c1)) continue;
                step(1'b1, fs_first && r == r0 && c == c0, pat(r, c));
                for (int g = 0; g < gap; g++) step(1'b0, 1'b0, rnd_pix());
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, 128'(window_valid), 128'(0));
        check_eq({tag, "_out"}, 128'(window_out), 128'(0));
`ifdef POOL_WIN_FRAME_DONE_EN
        check_eq({tag, "_done"}, 128'(frame_done), 128'(0));
`endif
    endtask

    initial begin
        pix_t [3:0] last_ch0;
        rstn           = 1'b0;
        frame_start    = 1'b0;
        pixel_in_valid = 1'b0;
        pixel_in       = '0;
        model_reset();
        pulses = 0;
        dones  = 0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;

        // Continuous frame.
        pulses = 0;
        send_rows(0, 0, H - 1, W - 1, 0, 1'b1);
        check_eq("pulses_continuous", 128'(pulses), 128'(4));
        last_ch0 = {16'sd51, 16'sd50, 16'sd35, 16'sd34};
        check_eq("last_window_ch0", 128'(window_out[0]), 128'(last_ch0));

        // Same frame with 3 idle cycles after each pixel.
        pulses = 0;
        send_rows(0, 0, H - 1, W - 1, 3, 1'b1);
        check_eq("pulses_gapped", 128'(pulses), 128'(4));

        // Two frames back to back relying on natural wrap.
        pulses = 0;
        dones  = 0;
        send_rows(0, 0, H - 1, W - 1, 0, 1'b0);
        send_rows(0, 0, H - 1, W - 1, 0, 1'b0);
        check_eq("pulses_two_frames", 128'(pulses), 128'(8));
`ifdef POOL_WIN_FRAME_DONE_EN
        check_eq("dones_two_frames", 128'(dones), 128'(2));
`endif

        // Abort after row 1; frame_start arrives where pixel (2,0) would be.
        pulses = 0;
        dones  = 0;
        send_rows(0, 0, 1, W - 1, 0, 1'b0);
        send_rows(0, 0, H - 1, W - 1, 0, 1'b1);
        check_eq("pulses_abort", 128'(pulses), 128'(6));
`ifdef POOL_WIN_FRAME_DONE_EN
        check_eq("dones_abort", 128'(dones), 128'(1));
`endif

        // Reset mid-frame after pixel (1,2).
        send_rows(0, 0, 1, 2, 0, 1'b0);
        pixel_in_valid = 1'b0;
        rstn = 1'b0;
        #1;
        check_reset_outputs("midreset0");
        repeat (2) begin
            @(posedge clk);
            #1;
            check_reset_outputs("midreset");
        end
        rstn = 1'b1;
        model_reset();
        pulses = 0;
        send_rows(0, 0, H - 1, W - 1, 0, 1'b0);
        check_eq("pulses_after_reset", 128'(pulses), 128'(4));

        // Randomized data, gaps and occasional frame restarts.
        for (int n = 0; n < 300; n++) begin
            step(1'b1, ($urandom_range(0, 19) == 0), rnd_pix());
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                step(1'b0, ($urandom_range(0, 29) == 0), rnd_pix());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
